// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared opcode constants and the immediate-format enum used by
//               the ID-stage immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

    // RV32I major opcodes handled by the immediate generator
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Immediate format reported alongside each decoded entry
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen_stage_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational RV32I immediate decoder. Extracts the immediate
//               for every format and sign-extends it to XLEN; shift amounts
//               are zero-extended and sized by XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    logic [31:0] w_imm32;
    logic        w_use32;
    logic [2:0]  w_funct3;

    assign w_funct3 = inst[14:12];

    // Select format and build the 32-bit signed immediate, then widen to XLEN
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        w_imm32 = '0;
        w_use32 = 1'b0;
        case (inst[6:0])
            OPC_OPIMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    fmt = FMT_SH;
                end else begin
                    fmt     = FMT_I;
                    w_imm32 = {{20{inst[31]}}, inst[31:20]};
                    w_use32 = 1'b1;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt     = FMT_I;
                w_imm32 = {{20{inst[31]}}, inst[31:20]};
                w_use32 = 1'b1;
            end
            OPC_STORE: begin
                fmt     = FMT_S;
                w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                w_use32 = 1'b1;
            end
            OPC_BRANCH: begin
                fmt     = FMT_B;
                w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                w_use32 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt     = FMT_U;
                w_imm32 = {inst[31:12], 12'b0};
                w_use32 = 1'b1;
            end
            OPC_JAL: begin
                fmt     = FMT_J;
                w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                w_use32 = 1'b1;
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            default: begin
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
        // Sign bit 31 is replicated upward first, then the low word overlaid
        if (w_use32) begin
            imm       = {XLEN{w_imm32[31]}};
            imm[31:0] = w_imm32;
        end else if (fmt == FMT_SH) begin
            imm[SHW-1:0] = inst[20 +: SHW];
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : Registered immediate generator for the ID stage. Decoded
//               results are held in a 2-entry skid buffer (head/tail) so that
//               in_ready_o depends on registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_inst_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_imm_o,
    output fmt_e             out_fmt_o,
    output logic             out_illegal_o,
    output logic [TAG_W-1:0] out_tag_o
);

    logic [XLEN-1:0]  w_dec_imm;
    fmt_e             w_dec_fmt;
    logic             w_dec_ill;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       r_count;
    logic [XLEN-1:0]  r_head_imm;
    fmt_e             r_head_fmt;
    logic             r_head_ill;
    logic [TAG_W-1:0] r_head_tag;
    logic [XLEN-1:0]  r_tail_imm;
    fmt_e             r_tail_fmt;
    logic             r_tail_ill;
    logic [TAG_W-1:0] r_tail_tag;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst    (in_inst_i),
        .imm     (w_dec_imm),
        .fmt     (w_dec_fmt),
        .illegal (w_dec_ill)
    );

    assign in_ready_o    = (r_count != 2'd2);
    assign out_valid_o   = (r_count != 2'd0);
    assign w_push        = in_valid_i && in_ready_o;
    assign w_pop         = out_valid_o && out_ready_i;

    // Head data is always presented; status fields are masked while empty
    assign out_imm_o     = r_head_imm;
    assign out_tag_o     = r_head_tag;
    assign out_fmt_o     = out_valid_o ? r_head_fmt : FMT_R;
    assign out_illegal_o = out_valid_o && r_head_ill;

    // Occupancy and entry storage; flush wins over any push or pop
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count    <= 2'd0;
            r_head_imm <= '0;
            r_head_fmt <= FMT_R;
            r_head_ill <= 1'b0;
            r_head_tag <= '0;
            r_tail_imm <= '0;
            r_tail_fmt <= FMT_R;
            r_tail_ill <= 1'b0;
            r_tail_tag <= '0;
        end else if (flush_i) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_imm <= w_dec_imm;
                        r_head_fmt <= w_dec_fmt;
                        r_head_ill <= w_dec_ill;
                        r_head_tag <= in_tag_i;
                        r_count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        // Old head leaves while the new entry takes its place
                        r_head_imm <= w_dec_imm;
                        r_head_fmt <= w_dec_fmt;
                        r_head_ill <= w_dec_ill;
                        r_head_tag <= in_tag_i;
                    end else if (w_push) begin
                        r_tail_imm <= w_dec_imm;
                        r_tail_fmt <= w_dec_fmt;
                        r_tail_ill <= w_dec_ill;
                        r_tail_tag <= in_tag_i;
                        r_count    <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    // in_ready_o is low here, so only a pop can occur
                    if (w_pop) begin
                        r_head_imm <= r_tail_imm;
                        r_head_fmt <= r_tail_fmt;
                        r_head_ill <= r_tail_ill;
                        r_head_tag <= r_tail_tag;
                        r_count    <= 2'd1;
                    end
                end
                default: begin
                    r_count <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_stage
// Description : Self-checking bench for imm_gen_stage. A 32-bit and a 64-bit
//               instance share one stimulus stream and are compared against
//               a queue-based reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] tag;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, v32, ill32;
    logic [31:0] imm32, tag32;
    logic [2:0]  fmt32;
    logic        rdy64, v64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [2:0]  fmt64;

    int compared = 0;
    int mismatched = 0;
    ent_t q[$];

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy32),
        .in_inst_i(in_inst), .in_tag_i(in_tag),
        .out_valid_o(v32), .out_ready_i(out_ready),
        .out_imm_o(imm32), .out_fmt_o(fmt32),
        .out_illegal_o(ill32), .out_tag_o(tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy64),
        .in_inst_i(in_inst), .in_tag_i(in_tag),
        .out_valid_o(v64), .out_ready_i(out_ready),
        .out_imm_o(imm64), .out_fmt_o(fmt64),
        .out_illegal_o(ill64), .out_tag_o(tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: immediate value as a plain integer, truncated to xlen
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input int xlen,
                                            output logic [2:0] fmt, output logic ill);
        longint v;
        logic [11:0] f12;
        logic [12:0] f13;
        logic [19:0] f20;
        logic [20:0] f21;
        v = 0; ill = 1'b0; fmt = 3'd7;
        case (inst[6:0])
            7'h13: begin
                if (inst[14:12] == 3'd1 || inst[14:12] == 3'd5) begin
                    fmt = 3'd6; v = longint'(inst[31:20]) % xlen;
                end else begin
                    fmt = 3'd1; f12 = inst[31:20]; v = longint'($signed(f12));
                end
            end
            7'h03, 7'h67: begin fmt = 3'd1; f12 = inst[31:20]; v = longint'($signed(f12)); end
            7'h23: begin fmt = 3'd2; f12 = {inst[31:25], inst[11:7]}; v = longint'($signed(f12)); end
            7'h63: begin
                fmt = 3'd3; f13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                v = longint'($signed(f13));
            end
            7'h37, 7'h17: begin fmt = 3'd4; f20 = inst[31:12]; v = longint'($signed(f20)) * 4096; end
            7'h6F: begin
                fmt = 3'd5; f21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                v = longint'($signed(f21));
            end
            7'h33: begin fmt = 3'd0; v = 0; end
            default: begin fmt = 3'd7; ill = 1'b1; v = 0; end
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return 64'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Compare one instance against the model head
    task automatic check_dut(input string nm, input int xlen, input logic v, input logic rdy,
                             input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                             input logic [31:0] tag);
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        chk({nm, "_valid"}, 64'(v), 64'(q.size() != 0));
        chk({nm, "_ready"}, 64'(rdy), 64'(q.size() != 2));
        if (q.size() != 0) begin
            e_imm = ref_imm(q[0].inst, xlen, e_fmt, e_ill);
            chk({nm, "_imm"}, imm, e_imm);
            chk({nm, "_fmt"}, 64'(fmt), 64'(e_fmt));
            chk({nm, "_ill"}, 64'(ill), 64'(e_ill));
            chk({nm, "_tag"}, 64'(tag), 64'(q[0].tag));
        end else begin
            chk({nm, "_fmt_empty"}, 64'(fmt), 64'd0);
            chk({nm, "_ill_empty"}, 64'(ill), 64'd0);
        end
    endtask

    task automatic check_all();
        check_dut("x32", 32, v32, rdy32, {32'b0, imm32}, fmt32, ill32, tag32);
        check_dut("x64", 64, v64, rdy64, imm64, fmt64, ill64, tag64);
    endtask

    // One clock: drive at negedge, advance model at posedge, check 1 ns later
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                         input logic rdy, input logic fl, output logic acc);
        logic pop;
        in_valid = v; in_inst = inst; in_tag = tag; out_ready = rdy; flush = fl;
        acc = v && (q.size() != 2);
        pop = (q.size() != 0) && rdy;
        @(posedge clk);
        if (fl) begin
            q.delete();
            acc = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{inst: inst, tag: tag});
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_v32"}, 64'(v32), 64'd0);
        chk({nm, "_rdy32"}, 64'(rdy32), 64'd1);
        chk({nm, "_imm32"}, 64'(imm32), 64'd0);
        chk({nm, "_fmt32"}, 64'(fmt32), 64'd0);
        chk({nm, "_ill32"}, 64'(ill32), 64'd0);
        chk({nm, "_tag32"}, 64'(tag32), 64'd0);
        chk({nm, "_v64"}, 64'(v64), 64'd0);
        chk({nm, "_imm64"}, imm64, 64'd0);
        chk({nm, "_tag64"}, 64'(tag64), 64'd0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        r = $urandom;
        if ($urandom_range(7) != 0) r[6:0] = ops[$urandom_range(9)];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // addi / sw with consumer always ready
        cycle(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, acc);
        chk("t1_addi_imm", 64'(imm32), 64'hFFFF_FFFF);
        chk("t1_addi_fmt", 64'(fmt32), 64'd1);
        cycle(1'b1, 32'hFE112E23, 32'h101, 1'b1, 1'b0, acc);
        chk("t1_sw_imm", 64'(imm32), 64'hFFFF_FFFC);
        chk("t1_sw_tag", 64'(tag32), 64'h101);

        // beq / srai
        cycle(1'b1, 32'hFE000CE3, 32'h200, 1'b1, 1'b0, acc);
        chk("t2_beq_imm", 64'(imm32), 64'hFFFF_FFF8);
        cycle(1'b1, 32'h4030D093, 32'h201, 1'b1, 1'b0, acc);
        chk("t2_srai_imm", 64'(imm32), 64'd3);
        chk("t2_srai_fmt", 64'(fmt32), 64'd6);

        // lui with positive and negative upper immediates on the 64-bit instance
        cycle(1'b1, 32'h123450B7, 32'h300, 1'b1, 1'b0, acc);
        chk("t3_lui_pos", imm64, 64'h0000_0000_1234_5000);
        cycle(1'b1, 32'h800000B7, 32'h301, 1'b1, 1'b0, acc);
        chk("t3_lui_neg", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("t3_lui_fmt", 64'(fmt64), 64'd4);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Back-pressure: tags 1,2 accepted, tag 3 held until space frees up
        cycle(1'b1, 32'h00100093, 32'd1, 1'b0, 1'b0, acc);
        chk("t4_acc1", 64'(acc), 64'd1);
        cycle(1'b1, 32'h00200093, 32'd2, 1'b0, 1'b0, acc);
        chk("t4_ready_low", 64'(rdy32), 64'd0);
        cycle(1'b1, 32'h00300093, 32'd3, 1'b0, 1'b0, acc);
        chk("t4_acc3_blocked", 64'(acc), 64'd0);
        chk("t4_head_tag1", 64'(tag32), 64'd1);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 6) begin
            cycle(1'b1, 32'h00300093, 32'd3, 1'b1, 1'b0, acc);
            n++;
        end
        chk("t4_acc3_eventually", 64'(acc), 64'd1);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Flush with a full buffer and a pending input
        cycle(1'b1, 32'h00500013, 32'h51, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00600013, 32'h52, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00700013, 32'h53, 1'b0, 1'b1, acc);
        chk("t5_flush_valid", 64'(v32), 64'd0);
        chk("t5_flush_ready", 64'(rdy64), 64'd1);
        cycle(1'b1, 32'h00800013, 32'h54, 1'b0, 1'b0, acc);
        chk("t5_after_flush_tag", 64'(tag32), 64'h54);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Illegal opcode, then asynchronous reset with one entry held
        cycle(1'b1, 32'h0000007F, 32'h61, 1'b0, 1'b0, acc);
        chk("t6_illegal", 64'(ill32), 64'd1);
        chk("t6_fmt_none", 64'(fmt64), 64'd7);
        chk("t6_imm_zero", imm64, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async_rst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(3) != 0), rand_inst(), $urandom,
                  1'($urandom_range(2) != 0), 1'($urandom_range(24) == 0), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate generator for the ID stage. Decodes all RV32I immediate formats (I, S, B, U, J, shift-amount) from a 32-bit instruction and sign-extends the result to XLEN. It sits behind a 2-entry valid/ready skid buffer so the decoder can absorb back-pressure from EX without combinational ready paths. It also carries a sideband tag (PC or ROB id) and reports format and illegal-opcode status.

Parameters:
XLEN, 32, datapath width of the immediate output; legal values 32 and 64.
TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-low.
flush_i  input  1  synchronous pipeline flush.
in_valid_i  input  1  instruction present.
in_ready_o  output  1  stage can accept.
in_inst_i  input  32  raw instruction.
in_tag_i  input  TAG_W  sideband tag.
out_valid_o  output  1  decoded entry present.
out_ready_i  input  1  consumer accepts.
out_imm_o  output  XLEN  sign-/zero-extended immediate.
out_fmt_o  output  3  format code (package enum).
out_illegal_o  output  1  opcode not in the supported set.
out_tag_o  output  TAG_W  tag of the head entry.

Behaviour:
- Reset (rst_i low, async): count=0; out_valid_o=0; out_imm_o, out_fmt_o, out_illegal_o and out_tag_o are 0; in_ready_o=1.
- Decode is combinational on the input side; decoded results are stored, not raw instructions.
  - OP-IMM 0010011: funct3 001 or 101 gives FMT_SH, imm = inst[20+SHW-1:20] zero-extended, where SHW = log2(XLEN). Other funct3 values give FMT_I.
  - LOAD 0000011 and JALR 1100111: FMT_I, imm = sext(inst[31:20]).
  - STORE 0100011: FMT_S, imm = sext({inst[31:25], inst[11:7]}).
  - BRANCH 1100011: FMT_B, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}). Bit 0 is always 0.
  - LUI 0110111 and AUIPC 0010111: FMT_U, imm = sext({inst[31:12], 12'b0}) to XLEN.
  - JAL 1101111: FMT_J, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - OP 0110011: FMT_R, imm = 0.
  - Any other opcode: FMT_NONE, imm = 0, illegal = 1. The entry is still enqueued.
- Buffer: 2 entries, head and tail, with count in {0,1,2}.
  - in_ready_o = (count != 2). It is a function of registered state only.
  - Push when in_valid_i && in_ready_o. Pop when out_valid_o && out_ready_i.
  - out_valid_o = (count != 0). Output ports always show the head entry.
- Latency: an instruction accepted at edge N is visible at the outputs after edge N; this is 1 cycle.
- Throughput: 1 per cycle with out_ready_i held high.
- Count transitions:
  - 0 with push: 1.
  - 1 with push only: 2.
  - 1 with pop only: 0.
  - 1 with push and pop together: stays 1, and the new entry becomes head.
  - 2 with pop: 1, and the tail moves to head. A push in this state is impossible because in_ready_o = 0.
- Ordering: strict FIFO; no reordering or dropping except on flush.
- Flush (flush_i high at an edge): count becomes 0 and out_valid_o becomes 0 after the edge.
  - Any push or pop in that cycle is discarded. The consumer must ignore a handshake it sees in a flush cycle.
  - Flush has priority over push and pop.
  - Data registers may hold stale values, but out_fmt_o and out_illegal_o read 0 while empty.
- Reset mid-operation: immediate return to the reset state, with no partial output.
- Outputs of the head entry are stable while out_valid_o && !out_ready_i.

Decomposition:
- Package imm_gen_pkg holds:
  - opcode localparams OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP;
  - fmt enum, 3 bits: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_SH=6, FMT_NONE=7.
- One sub-module, imm_decode: purely combinational. It maps inst to imm, fmt and illegal, parametrised by XLEN.
- The skid buffer and its control live in imm_gen_stage.

Test Plan:
1. XLEN=32, out_ready=1. Push 0xFFF00093 (addi x1,x0,-1), then 0xFE112E23 (sw x1,-4(x2)) on consecutive cycles. Expected:
   - out_imm 0xFFFFFFFF with FMT_I, one cycle after the first accept;
   - then 0xFFFFFFFC with FMT_S;
   - tags preserved in order.
2. XLEN=32. Push 0xFE000CE3 (beq x0,x0,-8), then 0x4030D093 (srai x1,x1,3). Expected:
   - imm 0xFFFFFFF8 with FMT_B;
   - then imm 0x00000003 with FMT_SH.
3. XLEN=64. Push 0x123450B7 (lui 0x12345), then 0x800000B7 (lui 0x80000). Expected:
   - 0x0000000012345000;
   - then 0xFFFFFFFF80000000;
   - both FMT_U.
4. Back-pressure: out_ready=0 while pushing tags 1, 2, 3 continuously. Expected:
   - tags 1 and 2 accepted; in_ready_o=0 from the cycle after the second accept;
   - tag 3 held by the source;
   - after raising out_ready, output order is 1, 2, 3 with no loss or duplication.
5. Flush: count=2 and in_valid=1, assert flush_i for one cycle. Expected:
   - out_valid_o=0 and in_ready_o=1 next cycle;
   - the flushed-cycle input never appears;
   - the next push appears after 1 cycle.
6. Illegal or async reset: push 0x0000007F. Expected: out_illegal_o=1, FMT_NONE, imm 0. Then pull rst_i low mid-transfer with count=1. Expected: out_valid_o=0 immediately, before the next clock edge, and all outputs 0.
